// File: rtl/sc_lives_regbank.sv
// sc_lives_regbank
// Holds the player's remaining lives as a 24-bit thermometer code. The code is split
// across three 8-bit rows that feed the all-rows-zero lose comparator. Each collision
// removes one life and then opens a grace window during which further hits are ignored.
// A load request refills the bank for a new game.
//
// Ports:
//   SC_LIVESBANK_CLOCK_50          system clock
//   SC_LIVESBANK_RESET_InHigh      synchronous active-high reset
//   SC_LIVESBANK_load_InLow        refill request, active low, level-sampled
//   SC_LIVESBANK_hit_InLow         collision, active low, acted on at its falling edge
//   SC_LIVESBANK_registro2_OutBUS  lives vector bits [23:16]
//   SC_LIVESBANK_registro1_OutBUS  lives vector bits [15:8]
//   SC_LIVESBANK_registro0_OutBUS  lives vector bits [7:0]
//   SC_LIVESBANK_lifelost_OutHigh  one-cycle pulse per removed life
//   SC_LIVESBANK_grace_OutHigh     high while in the grace window
//   SC_LIVESBANK_dead_OutHigh      high once all lives are gone
module sc_lives_regbank #(
    parameter int unsigned LIVESBANK_DATAWIDTH = 8,
    parameter int unsigned INIT_LIVES          = 3,
    parameter int unsigned GRACE_CYCLES        = 50000000
) (
    input  logic                           SC_LIVESBANK_CLOCK_50,
    input  logic                           SC_LIVESBANK_RESET_InHigh,
    input  logic                           SC_LIVESBANK_load_InLow,
    input  logic                           SC_LIVESBANK_hit_InLow,
    output logic [LIVESBANK_DATAWIDTH-1:0] SC_LIVESBANK_registro2_OutBUS,
    output logic [LIVESBANK_DATAWIDTH-1:0] SC_LIVESBANK_registro1_OutBUS,
    output logic [LIVESBANK_DATAWIDTH-1:0] SC_LIVESBANK_registro0_OutBUS,
    output logic                           SC_LIVESBANK_lifelost_OutHigh,
    output logic                           SC_LIVESBANK_grace_OutHigh,
    output logic                           SC_LIVESBANK_dead_OutHigh
);

    localparam int unsigned VEC_W = 3 * LIVESBANK_DATAWIDTH;
    // GRACE_CYCLES-1 must fit in the counter; keep at least one bit when GRACE_CYCLES is 1.
    localparam int unsigned CNT_W = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;
    localparam logic [VEC_W-1:0] REFILL     = VEC_W'((64'd1 << INIT_LIVES) - 64'd1);
    localparam logic [CNT_W-1:0] GRACE_LOAD = CNT_W'(GRACE_CYCLES - 1);

    typedef enum logic [1:0] {
        StAlive,
        StGrace,
        StDead
    } state_t;

    state_t             stateQ, stateD;
    logic [VEC_W-1:0]   vectorQ, vectorD;
    logic [CNT_W-1:0]   graceCntQ, graceCntD;
    logic               lifelostQ, lifelostD;
    logic               hitPrevQ;
    logic               hitEvent;

    // State register
    always_ff @(posedge SC_LIVESBANK_CLOCK_50) begin
        if (SC_LIVESBANK_RESET_InHigh) begin
            stateQ    <= StAlive;
            vectorQ   <= REFILL;
            graceCntQ <= '0;
            lifelostQ <= 1'b0;
            hitPrevQ  <= 1'b1;
        end else begin
            stateQ    <= stateD;
            vectorQ   <= vectorD;
            graceCntQ <= graceCntD;
            lifelostQ <= lifelostD;
            // Tracks the raw input in every state, so a hit held low through the end of
            // grace never looks like a fresh falling edge.
            hitPrevQ  <= SC_LIVESBANK_hit_InLow;
        end
    end

    assign hitEvent = ~SC_LIVESBANK_hit_InLow & hitPrevQ;

    // Next-state logic
    always_comb begin
        stateD    = stateQ;
        vectorD   = vectorQ;
        graceCntD = graceCntQ;
        lifelostD = 1'b0;
        if (!SC_LIVESBANK_load_InLow) begin
            // Load wins over any coincident hit, in every state.
            stateD    = StAlive;
            vectorD   = REFILL;
            graceCntD = '0;
        end else begin
            case (stateQ)
                StAlive: begin
                    if (hitEvent) begin
                        vectorD   = vectorQ >> 1;
                        lifelostD = 1'b1;
                        // Bit 1 set means at least two lives remain before the shift.
                        if (vectorQ[1]) begin
                            graceCntD = GRACE_LOAD;
                            stateD    = StGrace;
                        end else begin
                            stateD = StDead;
                        end
                    end
                end
                StGrace: begin
                    if (graceCntQ == '0) begin
                        stateD = StAlive;
                    end else begin
                        graceCntD = graceCntQ - 1'b1;
                    end
                end
                StDead: begin
                    vectorD = '0;
                end
                default: begin
                    stateD = StAlive;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        SC_LIVESBANK_grace_OutHigh = (stateQ == StGrace);
        SC_LIVESBANK_dead_OutHigh  = (stateQ == StDead);
    end

    assign SC_LIVESBANK_lifelost_OutHigh = lifelostQ;
    assign SC_LIVESBANK_registro2_OutBUS = vectorQ[3*LIVESBANK_DATAWIDTH-1:2*LIVESBANK_DATAWIDTH];
    assign SC_LIVESBANK_registro1_OutBUS = vectorQ[2*LIVESBANK_DATAWIDTH-1:LIVESBANK_DATAWIDTH];
    assign SC_LIVESBANK_registro0_OutBUS = vectorQ[LIVESBANK_DATAWIDTH-1:0];

endmodule

// File: tb/tb_sc_lives_regbank.sv
// Bench for sc_lives_regbank: two instances (3 lives and 24 lives, short grace window)
// driven by directed and random stimulus. A lives-count reference model pushes the
// expected outputs for each clock edge into a scoreboard; a monitor pops and compares.
module tb_sc_lives_regbank;

    localparam int G = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstIn[2];
    logic       loadIn[2];
    logic       hitIn[2];
    logic [7:0] r2[2];
    logic [7:0] r1[2];
    logic [7:0] r0[2];
    logic       lostOut[2];
    logic       graceOut[2];
    logic       deadOut[2];

    sc_lives_regbank #(
        .LIVESBANK_DATAWIDTH(8),
        .INIT_LIVES(3),
        .GRACE_CYCLES(G)
    ) dutA (
        .SC_LIVESBANK_CLOCK_50(clk),
        .SC_LIVESBANK_RESET_InHigh(rstIn[0]),
        .SC_LIVESBANK_load_InLow(loadIn[0]),
        .SC_LIVESBANK_hit_InLow(hitIn[0]),
        .SC_LIVESBANK_registro2_OutBUS(r2[0]),
        .SC_LIVESBANK_registro1_OutBUS(r1[0]),
        .SC_LIVESBANK_registro0_OutBUS(r0[0]),
        .SC_LIVESBANK_lifelost_OutHigh(lostOut[0]),
        .SC_LIVESBANK_grace_OutHigh(graceOut[0]),
        .SC_LIVESBANK_dead_OutHigh(deadOut[0])
    );

    sc_lives_regbank #(
        .LIVESBANK_DATAWIDTH(8),
        .INIT_LIVES(24),
        .GRACE_CYCLES(G)
    ) dutB (
        .SC_LIVESBANK_CLOCK_50(clk),
        .SC_LIVESBANK_RESET_InHigh(rstIn[1]),
        .SC_LIVESBANK_load_InLow(loadIn[1]),
        .SC_LIVESBANK_hit_InLow(hitIn[1]),
        .SC_LIVESBANK_registro2_OutBUS(r2[1]),
        .SC_LIVESBANK_registro1_OutBUS(r1[1]),
        .SC_LIVESBANK_registro0_OutBUS(r0[1]),
        .SC_LIVESBANK_lifelost_OutHigh(lostOut[1]),
        .SC_LIVESBANK_grace_OutHigh(graceOut[1]),
        .SC_LIVESBANK_dead_OutHigh(deadOut[1])
    );

    typedef struct {
        int unsigned      tag;
        logic [1:0][23:0] rows;
        logic [1:0]       lost;
        logic [1:0]       grc;
        logic [1:0]       dd;
    } exp_t;

    exp_t sb[$];

    // Reference model: lives as an integer, grace as cycles still to show.
    int initLives[2];
    int lives[2];
    int graceLeft[2];
    bit prevHit[2];
    bit isDead[2];
    bit lostPulse[2];

    int unsigned edgeCnt = 0;
    int checks = 0;
    int passes = 0;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    function automatic void modelStep(int i);
        bit hitEv;
        if (rstIn[i]) begin
            lives[i]     = initLives[i];
            graceLeft[i] = 0;
            prevHit[i]   = 1'b1;
            isDead[i]    = 1'b0;
            lostPulse[i] = 1'b0;
        end else begin
            hitEv        = !hitIn[i] && prevHit[i];
            prevHit[i]   = hitIn[i];
            lostPulse[i] = 1'b0;
            if (!loadIn[i]) begin
                lives[i]     = initLives[i];
                graceLeft[i] = 0;
                isDead[i]    = 1'b0;
            end else if (isDead[i]) begin
                lives[i] = 0;
            end else if (graceLeft[i] > 0) begin
                graceLeft[i]--;
            end else if (hitEv) begin
                lives[i]--;
                lostPulse[i] = 1'b1;
                if (lives[i] == 0) isDead[i] = 1'b1;
                else graceLeft[i] = G;
            end
        end
    endfunction

    // Predict the outputs after the coming edge, then let that edge happen.
    task automatic step();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            modelStep(i);
            e.rows[i] = 24'((64'd1 << lives[i]) - 64'd1);
            e.lost[i] = lostPulse[i];
            e.grc[i]  = (graceLeft[i] > 0);
            e.dd[i]   = isDead[i];
        end
        e.tag = edgeCnt + 1;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic check(string name, int i, logic [23:0] act, logic [23:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s inst%0d edge %0d: got %h, expected %h", name, i, edgeCnt, act, exp);
    endtask

    // Monitor: compare whenever the scoreboard holds the expectation for the last edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].tag == edgeCnt) begin
                e = sb.pop_front();
                for (int i = 0; i < 2; i++) begin
                    check("rows", i, {r2[i], r1[i], r0[i]}, e.rows[i]);
                    check("lifelost", i, 24'(lostOut[i]), 24'(e.lost[i]));
                    check("grace", i, 24'(graceOut[i]), 24'(e.grc[i]));
                    check("dead", i, 24'(deadOut[i]), 24'(e.dd[i]));
                end
            end
        end
    end

    initial begin
        initLives[0] = 3;
        initLives[1] = 24;
        for (int i = 0; i < 2; i++) begin
            rstIn[i]  = 1'b1;
            loadIn[i] = 1'b1;
            hitIn[i]  = 1'b1;
            lives[i]  = 0;
        end
        step();
        rstIn[0] = 1'b0;
        rstIn[1] = 1'b0;
        repeat (2) step();

        // First hit on both banks.
        hitIn[0] = 1'b0;
        hitIn[1] = 1'b0;
        step();
        hitIn[1] = 1'b1;
        // A toggles through grace; B is reset mid-grace.
        hitIn[0] = 1'b1;
        step();
        hitIn[0] = 1'b0;
        rstIn[1] = 1'b1;
        step();
        rstIn[1] = 1'b0;
        hitIn[0] = 1'b1;
        step();
        // Held low across the end of grace: must not count.
        hitIn[0] = 1'b0;
        repeat (6) step();
        // Release and reassert: second life lost.
        hitIn[0] = 1'b1;
        step();
        hitIn[0] = 1'b0;
        step();
        hitIn[0] = 1'b1;
        repeat (6) step();
        // Third hit: dead.
        hitIn[0] = 1'b0;
        step();
        hitIn[0] = 1'b1;
        repeat (2) step();
        // Fourth hit while dead: ignored.
        hitIn[0] = 1'b0;
        step();
        hitIn[0] = 1'b1;
        repeat (2) step();
        // Load in DEAD.
        loadIn[0] = 1'b0;
        step();
        loadIn[0] = 1'b1;
        repeat (2) step();
        // Load and hit together while ALIVE: load wins.
        loadIn[0] = 1'b0;
        hitIn[0]  = 1'b0;
        step();
        loadIn[0] = 1'b1;
        hitIn[0]  = 1'b1;
        repeat (2) step();

        // Random phase.
        repeat (600) begin
            for (int i = 0; i < 2; i++) begin
                hitIn[i]  = 1'($urandom_range(0, 1));
                loadIn[i] = ($urandom_range(0, 29) != 0);
                rstIn[i]  = ($urandom_range(0, 59) == 0);
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            rstIn[i]  = 1'b0;
            loadIn[i] = 1'b1;
            hitIn[i]  = 1'b1;
        end

        // Bounded drain of the scoreboard.
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending, expected 0", sb.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sc_lives_regbank.md
# sc_lives_regbank

Sequential register bank holding the player's remaining lives as a 24-bit thermometer code split across three 8-bit rows. It sits directly upstream of the all-rows-zero lose comparator: its three row buses drive the comparator's three inputs, so the comparator flags game over exactly when this bank has run out of lives. Collision events remove one life each, separated by a post-hit grace window. A load request refills the bank for a new game.

## Interface
- LIVESBANK_DATAWIDTH, 8: width of each row bus; fixed at 8, and the thermometer vector is 3×8 = 24 bits.
- INIT_LIVES, 3: lives loaded at reset and on load; legal range 1..24.
- GRACE_CYCLES, 50000000: post-hit invulnerability length in clock cycles (1 s at 50 MHz); must be ≥1.

- SC_LIVESBANK_CLOCK_50  input  1  system clock; single clock domain.
- SC_LIVESBANK_RESET_InHigh  input  1  reset: synchronous, active-high.
- SC_LIVESBANK_load_InLow  input  1  refill request, active low, level-sampled.
- SC_LIVESBANK_hit_InLow  input  1  collision indication, active low; acted on at assertion edge only.
- SC_LIVESBANK_registro2_OutBUS  output  8  vector bits [23:16].
- SC_LIVESBANK_registro1_OutBUS  output  8  vector bits [15:8].
- SC_LIVESBANK_registro0_OutBUS  output  8  vector bits [7:0].
- SC_LIVESBANK_lifelost_OutHigh  output  1  one-cycle pulse when a life is removed.
- SC_LIVESBANK_grace_OutHigh  output  1  high while in GRACE; used by the display for blinking.
- SC_LIVESBANK_dead_OutHigh  output  1  high while in DEAD.

## Operation
- Vector format: the lowest N bits are set, where N is the remaining lives (thermometer code). All three row outputs are driven directly from registers.
- Refill value: (1<<INIT_LIVES)-1.
- Losing a life: the vector shifts right logically by one, with 0 shifted into bit 23. This removes exactly one life.
- Edge detect: register hit_prev, reset value 1. A hit event is a sample of hit_InLow==0 while hit_prev==1.
- State machine, three states (ALIVE, GRACE, DEAD):
  - ALIVE + hit event, more than one life left: shift the vector, pulse lifelost, load the grace counter with GRACE_CYCLES-1, go to GRACE.
  - ALIVE + hit event, exactly one life left: shift the vector (now all zero), pulse lifelost, go to DEAD.
  - GRACE: all hit events are ignored. The counter decrements each cycle. At 0 the state returns to ALIVE on the next edge.
  - DEAD: the vector holds zero and hits are ignored.
- Load, active in any state: set the vector to the refill value, go to ALIVE, clear the grace counter, keep lifelost low.
- Load priority: load beats a hit in the same cycle, and the hit is discarded. While load is held low, the bank stays refilled and in ALIVE.
- A hit held low across the end of the grace window does not count. A new high→low transition is required.
- Reset values:
  - vector = refill value; all three row outputs hold it.
  - state = ALIVE.
  - lifelost = 0, grace = 0, dead = 0.
  - grace counter = 0, hit_prev = 1.

## Timing
- Hit latency: hit_InLow is sampled low at edge k (with hit_prev high), and the rows, lifelost, grace/dead and state all update at the same edge k. They are visible during cycle k→k+1, so the latency is 1 clock.
- lifelost is exactly one cycle wide per removed life.
- Grace duration: grace_OutHigh is high for exactly GRACE_CYCLES cycles. The first hit that can count is one first sampled GRACE_CYCLES+1 edges after the removing edge.
- Load latency: load sampled low at edge k gives the refilled vector from edge k.
- Reset latency: reset sampled high at edge k puts all outputs at their reset values after edge k. Reset mid-GRACE or in DEAD behaves identically, with no residual pulse.
- Downstream comparator: it is combinational, so the lose flag rises in the same cycle the vector reaches zero.

## Test plan
- Reset, INIT_LIVES=3 -> rows 0x00/0x00/0x07; lifelost=0, grace=0, dead=0.
- Single hit pulse, GRACE_CYCLES=4 -> next cycle rows0=0x03, one-cycle lifelost pulse, grace high for exactly 4 cycles, then ALIVE.
- Hit toggled every cycle during grace -> rows0 stays 0x03 with no lifelost pulses. A hit held low past grace end does not count; release and reassert -> rows0=0x01.
- Three spaced hits from 3 lives -> rows0=0x00, dead=1, grace=0. A fourth hit gives no change and no pulse.
- Load in DEAD, and load plus hit in the same cycle while ALIVE -> rows0=0x07, state ALIVE, no lifelost pulse.
- INIT_LIVES=24 -> rows 0xFF/0xFF/0xFF. One hit -> 0x7F/0xFF/0xFF. Reset asserted mid-grace -> 0xFF/0xFF/0xFF, grace=0 next cycle.
